// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits sent LSB first,
// an optional parity bit and 1 or 2 stop bits. Bit timing comes from the system clock.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 accept;
  logic                 tick;

  // Gating with rst_n keeps in_ready low for the whole time reset is held.
  assign in_ready = rst_n & en & (state == S_IDLE);
  assign accept   = in_valid & in_ready;
  assign tick     = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = S_START;
      S_START:  if (tick) state_next = S_DATA;
      S_DATA:   if (tick && bit_idx == IDX_W'(DATA_BITS - 1))
                  state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_next = S_STOP;
      S_STOP:   if (tick && bit_idx == IDX_W'(STOP_BITS - 1)) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // NOTE: the datapath is reset too, so an aborted frame leaves no stale bits behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == S_STOP) && (state_next == S_IDLE);
      if (state == S_IDLE) begin
        baud_cnt <= '0;
        bit_idx  <= '0;
        if (accept) begin
          shreg   <= in_data;
          par_bit <= (PARITY == 1) ? ~^in_data : ^in_data;
        end
      end else if (tick) begin
        baud_cnt <= '0;
        // bit_idx counts data bits in DATA and stop bits in STOP.
        bit_idx  <= (state_next != state) ? '0 : bit_idx + 1'b1;
        if (state == S_DATA) shreg <= shreg >> 1;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    case (state)
      S_IDLE:   busy = 1'b0;
      S_START:  tx   = 1'b0;
      S_DATA:   tx   = shreg[0];
      S_PARITY: tx   = par_bit;
      S_STOP:   tx   = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations share one stimulus stream and are
// compared every cycle against a per-cycle expected line waveform built from the frame format.
module tb_uart_tx_param;

  localparam int N   = 4;
  localparam int CPB = 4;
  localparam int DB  [N] = '{8, 8, 8, 7};
  localparam int PAR [N] = '{0, 2, 1, 0};
  localparam int STB [N] = '{1, 1, 1, 2};
  // Hand-computed frame lengths and first-frame line patterns (bit k = k-th bit on the line).
  localparam int         LEN    [N] = '{40, 44, 44, 40};
  localparam logic [10:0] FRAME0 [N] = '{11'h2AA, 11'h546, 11'h746, 11'h382};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic [8:0] in_data_v [N];
  logic [N-1:0] tx_v, busy_v, done_v, ready_v;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx_param #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB[g]),
      .PARITY      (PAR[g]),
      .STOP_BITS   (STB[g])
    ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .in_valid(in_valid),
      .in_data (in_data_v[g][DB[g]-1:0]),
      .in_ready(ready_v[g]),
      .tx      (tx_v[g]),
      .busy    (busy_v[g]),
      .done    (done_v[g])
    );
  end

  int vectors = 0;
  int errors  = 0;

  // Reference model: the remaining line levels of the current frame, one entry per cycle.
  bit          exp_q [N][$];
  logic        done_pend [N];
  int          cyc [N];
  logic [10:0] cap [N];
  logic        first_seen [N];
  logic        busy_e [N];
  logic        tx_e [N];
  logic        rdy_e [N];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, idx, $time, act, exp);
    end
  endtask

  task automatic push_bit(input int i, input bit v);
    repeat (CPB) exp_q[i].push_back(v);
  endtask

  task automatic push_frame(input int i, input logic [8:0] d);
    int ones = 0;
    push_bit(i, 1'b0);
    for (int b = 0; b < DB[i]; b++) begin
      push_bit(i, d[b]);
      ones += int'(d[b]);
    end
    // Parity bit makes the total count of ones odd (mode 1) or even (mode 2).
    if (PAR[i] == 2) push_bit(i, bit'(ones % 2));
    if (PAR[i] == 1) push_bit(i, bit'(1 - ones % 2));
    for (int s = 0; s < STB[i]; s++) push_bit(i, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      done_pend[i]  = 1'b0;
      cyc[i]        = 0;
      cap[i]        = '0;
      first_seen[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        exp_q[i].delete();
        done_pend[i] = 1'b0;
      end
      busy_e[i] = (exp_q[i].size() != 0);
      tx_e[i]   = busy_e[i] ? exp_q[i][0] : 1'b1;
      rdy_e[i]  = rst_n && en && !busy_e[i];

      check("tx",       i, 32'(tx_v[i]),    32'(tx_e[i]));
      check("busy",     i, 32'(busy_v[i]),  32'(busy_e[i]));
      check("done",     i, 32'(done_v[i]),  32'(done_pend[i]));
      check("in_ready", i, 32'(ready_v[i]), 32'(rdy_e[i]));

      if (!first_seen[i] && busy_e[i] && (cyc[i] % CPB) == 1) cap[i][cyc[i] / CPB] = tx_v[i];
      if (done_pend[i]) begin
        check("frame_len", i, 32'(cyc[i]), 32'(LEN[i]));
        if (!first_seen[i]) begin
          check("first_frame_bits", i, 32'(cap[i]), 32'(FRAME0[i]));
          first_seen[i] = 1'b1;
        end
      end

      if (busy_e[i]) begin
        void'(exp_q[i].pop_front());
        done_pend[i] = (exp_q[i].size() == 0);
      end else begin
        done_pend[i] = 1'b0;
      end
      cyc[i]++;
      if (!busy_e[i] && in_valid && rdy_e[i]) begin
        push_frame(i, in_data_v[i] & 9'((1 << DB[i]) - 1));
        cyc[i] = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [8:0] d);
    for (int i = 0; i < N; i++) in_data_v[i] = d;
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    set_data(9'h000);
    step(3);
    rst_n = 1'b1;
    step(2);

    // First frame: 0x55 (8N1), 0xA3 (even / odd parity), 7'h41 (7N2).
    en           = 1'b1;
    in_valid     = 1'b1;
    in_data_v[0] = 9'h055;
    in_data_v[1] = 9'h0A3;
    in_data_v[2] = 9'h0A3;
    in_data_v[3] = 9'h041;
    step(1);
    in_valid = 1'b0;
    step(50);

    // Back-to-back frames with in_valid held high.
    in_valid = 1'b1;
    set_data(9'h012);
    step(20);
    set_data(9'h034);
    step(30);
    in_valid = 1'b0;
    step(60);

    // in_valid pending while disabled, then enabled.
    en       = 1'b0;
    in_valid = 1'b1;
    set_data(9'h05A);
    step(20);
    en = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(60);

    // Reset mid-DATA, then a clean frame of all ones.
    in_valid = 1'b1;
    set_data(9'h000);
    step(1);
    in_valid = 1'b0;
    step(10);
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
    in_valid = 1'b1;
    set_data(9'h1FF);
    step(1);
    in_valid = 1'b0;
    step(60);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      en       = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      rst_n    = ($urandom_range(0, 599) != 0);
      for (int i = 0; i < N; i++) in_data_v[i] = 9'($urandom);
      step(1);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
